// File: rtl/ram_b_arbiter.sv
// ram_b_arbiter -- two-master sequencer in front of the 128 B data RAM.
//
// Master 0 is the core MEM stage, master 1 the debug/DMA loader. One request
// is latched, driven onto the RAM for a single ACCESS cycle, and the result
// (read data + fault flags) is returned registered in the following RESP cycle.
//
// Build option: define RAM_ARB_RR_EN for round-robin arbitration between the
// two masters; left undefined, master 0 wins every simultaneous request.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mN_req/we/addr/wdata/ubhw request from master N (held until mN_gnt)
//   mN_gnt                    1-cycle pulse in ACCESS, request latched
//   mN_rvalid                 1-cycle pulse in RESP, mN_rdata/mN_err valid
//   mN_rdata, mN_err          registered result {illegal, s_fault, l_fault}
//   busy                      sequencer not idle
//   ram_addr/din/ubhw/we/re   RAM drive, live only in ACCESS
//   ram_dout, ram_lf/sf/ia    RAM combinational read data and fault flags

module ram_b_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [2:0]        m0_ubhw,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [2:0]        m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [2:0]        m1_ubhw,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [2:0]        m1_err,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   output logic              ram_re,
   output logic [2:0]        ram_ubhw,
   input  logic [DATA_W-1:0] ram_dout,
   input  logic              ram_lf,
   input  logic              ram_sf,
   input  logic              ram_ia
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t            state_q, state_d;
   logic              lat_we_q, lat_we_d;
   logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
   logic [2:0]        lat_ubhw_q, lat_ubhw_d;
   logic              owner_q, owner_d;      // 0 = m0, 1 = m1
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
   logic [2:0]        m0_err_q, m0_err_d, m1_err_q, m1_err_d;
`ifdef RAM_ARB_RR_EN
   logic              rr_q, rr_d;            // last owner
`endif

   logic any_req, win, in_acc, in_resp;

   assign any_req = m0_req | m1_req;

`ifdef RAM_ARB_RR_EN
   // On a tie the master that did not own the last grant wins.
   assign win = (m0_req & m1_req) ? ~rr_q : m1_req;
`else
   assign win = ~m0_req;
`endif

   always_comb begin
      state_d     = state_q;
      lat_we_d    = lat_we_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      lat_ubhw_d  = lat_ubhw_q;
      owner_d     = owner_q;
      m0_rdata_d  = m0_rdata_q;
      m0_err_d    = m0_err_q;
      m1_rdata_d  = m1_rdata_q;
      m1_err_d    = m1_err_q;
`ifdef RAM_ARB_RR_EN
      rr_d        = rr_q;
`endif
      case (state_q)
         S_ACCESS: begin
            if (owner_q) begin
               m1_rdata_d = lat_we_q ? '0 : ram_dout;
               m1_err_d   = {ram_ia, ram_sf, ram_lf};
            end else begin
               m0_rdata_d = lat_we_q ? '0 : ram_dout;
               m0_err_d   = {ram_ia, ram_sf, ram_lf};
            end
            state_d = S_RESP;
         end
         default: begin
            // IDLE and RESP share the arbitration path; RESP falls back to
            // IDLE when nothing is pending.
            if (state_q == S_RESP) state_d = S_IDLE;
            if (any_req) begin
               state_d     = S_ACCESS;
               owner_d     = win;
               lat_we_d    = win ? m1_we    : m0_we;
               lat_addr_d  = win ? m1_addr  : m0_addr;
               lat_wdata_d = win ? m1_wdata : m0_wdata;
               lat_ubhw_d  = win ? m1_ubhw  : m0_ubhw;
`ifdef RAM_ARB_RR_EN
               rr_d        = win;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         lat_ubhw_q  <= '0;
         owner_q     <= 1'b0;
         m0_rdata_q  <= '0;
         m0_err_q    <= '0;
         m1_rdata_q  <= '0;
         m1_err_q    <= '0;
`ifdef RAM_ARB_RR_EN
         rr_q        <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         lat_we_q    <= lat_we_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
         lat_ubhw_q  <= lat_ubhw_d;
         owner_q     <= owner_d;
         m0_rdata_q  <= m0_rdata_d;
         m0_err_q    <= m0_err_d;
         m1_rdata_q  <= m1_rdata_d;
         m1_err_q    <= m1_err_d;
`ifdef RAM_ARB_RR_EN
         rr_q        <= rr_d;
`endif
      end
   end

   // Gating with ~rst keeps a store caught by reset from reaching the RAM's
   // negedge write, and suppresses pulses for a transaction being dropped.
   assign in_acc  = (state_q == S_ACCESS) & ~rst;
   assign in_resp = (state_q == S_RESP) & ~rst;

   assign m0_gnt    = in_acc & ~owner_q;
   assign m1_gnt    = in_acc & owner_q;
   assign m0_rvalid = in_resp & ~owner_q;
   assign m1_rvalid = in_resp & owner_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign m0_err    = m0_err_q;
   assign m1_err    = m1_err_q;
   assign busy      = (state_q != S_IDLE);

   assign ram_we   = in_acc & lat_we_q;
   assign ram_re   = in_acc & ~lat_we_q;
   assign ram_addr = in_acc ? lat_addr_q  : '0;
   assign ram_din  = in_acc ? lat_wdata_q : '0;
   assign ram_ubhw = in_acc ? lat_ubhw_q  : '0;

endmodule

// File: tb/tb_ram_b_arbiter.sv
module tb_ram_b_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [2:0]  m0_ubhw, m1_ubhw;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic [2:0]  m0_err, m1_err;
   logic        busy, ram_we, ram_re, ram_lf, ram_sf, ram_ia;
   logic [31:0] ram_addr, ram_din, ram_dout;
   logic [2:0]  ram_ubhw;

   typedef struct {logic [31:0] d; logic [2:0] e;} exp_t;
   exp_t exp_q0[$], exp_q1[$];
   int   glog[$];
   int   n_chk = 0, n_fail = 0, cyc = 0;

   logic [7:0] ram_mem [128];
   logic [7:0] ref_mem [128];

   ram_b_arbiter dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ubhw(m0_ubhw),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ubhw(m1_ubhw),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .busy(busy), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_re(ram_re),
      .ram_ubhw(ram_ubhw), .ram_dout(ram_dout), .ram_lf(ram_lf), .ram_sf(ram_sf), .ram_ia(ram_ia)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // RAM fault rules: misalignment -> illegal_addr; beyond 128 B -> access fault.
   function automatic logic [2:0] flt(input logic we, input logic [31:0] a, input logic [2:0] u);
      logic ia, oor;
      int   n;
      n   = u[1] ? 4 : (u[0] ? 2 : 1);
      ia  = (u[1] && a[1:0] != 2'b00) || (!u[1] && u[0] && a[0]);
      oor = (64'(a) + 64'(n)) > 64'd128;
      return {ia, we & oor, ~we & oor};
   endfunction

   function automatic logic [31:0] ext(input logic [31:0] raw, input logic [2:0] u);
      if (u[1]) return raw;
      if (u[0]) return u[2] ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      return u[2] ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
   endfunction

   // RAM model: combinational read, negedge write, faulting accesses do nothing.
   always_comb begin
      logic [31:0] raw;
      logic [2:0]  f;
      raw = '0;
      for (int k = 0; k < 4; k++) raw[8*k +: 8] = ram_mem[(ram_addr[6:0] + 7'(k))];
      f        = flt(ram_we, ram_addr, ram_ubhw);
      {ram_ia, ram_sf, ram_lf} = (ram_we | ram_re) ? f : 3'b000;
      ram_dout = (ram_re && f == 3'b000) ? ext(raw, ram_ubhw) : 32'h0;
   end

   always @(negedge clk) begin
      if (ram_we && flt(1'b1, ram_addr, ram_ubhw) == 3'b000)
         for (int k = 0; k < 4; k++)
            if (k < (ram_ubhw[1] ? 4 : (ram_ubhw[0] ? 2 : 1)))
               ram_mem[ram_addr[6:0] + 7'(k)] <= ram_din[8*k +: 8];
   end

   // Output monitor: score rvalid data, log grant order, check ACCESS-only write.
   always @(negedge clk) begin
      exp_t e;
      if (m0_gnt) glog.push_back(0);
      if (m1_gnt) glog.push_back(1);
      if (m0_gnt | m1_gnt) chk("gnt_onehot", m0_gnt & m1_gnt, 0);
      if (ram_we) chk("we_only_access", m0_gnt | m1_gnt, 1);
      if (m0_rvalid | m1_rvalid) chk("rvalid_onehot", m0_rvalid & m1_rvalid, 0);
      if (m0_rvalid) begin
         if (exp_q0.size() == 0) chk("m0_rv_unexpected", 1, 0);
         else begin
            e = exp_q0.pop_front();
            chk("m0_rdata", m0_rdata, e.d);
            chk("m0_err", m0_err, e.e);
         end
      end
      if (m1_rvalid) begin
         if (exp_q1.size() == 0) chk("m1_rv_unexpected", 1, 0);
         else begin
            e = exp_q1.pop_front();
            chk("m1_rdata", m1_rdata, e.d);
            chk("m1_err", m1_err, e.e);
         end
      end
   end

   // One transaction: push the expected result, hold req until gnt, then
   // confirm rvalid arrives the cycle after gnt. wt = cycles waited for gnt.
   task automatic xact(input int m, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] u, output int wt, output int gc);
      exp_t        e;
      logic [31:0] raw;
      logic        got;
      e.e = flt(we, a, u);
      raw = '0;
      for (int k = 0; k < 4; k++) raw[8*k +: 8] = ref_mem[a[6:0] + 7'(k)];
      e.d = (we || e.e != 3'b000) ? 32'h0 : ext(raw, u);
      if (we && e.e == 3'b000)
         for (int k = 0; k < (u[1] ? 4 : (u[0] ? 2 : 1)); k++) ref_mem[a[6:0] + 7'(k)] = wd[8*k +: 8];
      if (m == 0) begin
         exp_q0.push_back(e);
         m0_we = we; m0_addr = a; m0_wdata = wd; m0_ubhw = u; m0_req = 1'b1;
      end else begin
         exp_q1.push_back(e);
         m1_we = we; m1_addr = a; m1_wdata = wd; m1_ubhw = u; m1_req = 1'b1;
      end
      wt = 0; got = 1'b0;
      while (!got && wt < 50) begin
         @(posedge clk); #1;
         wt++;
         got = (m == 0) ? m0_gnt : m1_gnt;
      end
      gc = cyc;
      if (!got) chk("gnt_timeout", 0, 1);
      if (m == 0) m0_req = 1'b0; else m1_req = 1'b0;
      @(posedge clk); #1;
      chk("rvalid_after_gnt", (m == 0) ? m0_rvalid : m1_rvalid, 1);
   endtask

   initial begin
      int w0, g0, w1, g1, wa, ga, wb, gb;
      int exp_ord[4];
      logic got;
      int   k;
      for (int i = 0; i < 128; i++) begin
         ram_mem[i] <= 8'(i * 3 + 1);
         ref_mem[i] = 8'(i * 3 + 1);
      end
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_ubhw = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_ubhw = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
      chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
      chk("rst_ram_ctl", {ram_we, ram_re, ram_ubhw}, 0);
      chk("rst_ram_addr_din", {ram_addr, ram_din}, 0);
      chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
      chk("rst_err", {m0_err, m1_err}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 1: byte store then signed byte load, latency 1 cycle to gnt
      xact(0, 1'b1, 32'h10, 32'hA5, 3'b000, w0, g0);
      chk("t1_gnt_latency", w0, 1);
      xact(0, 1'b0, 32'h10, 32'h0, 3'b000, w0, g1);
      chk("t1_load_gnt_latency", w0, 1);
      chk("t1_back_to_back", g1 - g0, 2);
      @(posedge clk); #1;
      chk("t1_idle", busy, 0);

      // 2/3: both masters request together, two loads each
`ifdef RAM_ARB_RR_EN
      exp_ord = '{1, 0, 1, 0};
`else
      exp_ord = '{0, 0, 1, 1};
`endif
      glog.delete();
      fork
         begin
            xact(0, 1'b0, 32'h40, 32'h0, 3'b010, wa, ga);
            xact(0, 1'b0, 32'h44, 32'h0, 3'b101, wa, ga);
         end
         begin
            xact(1, 1'b0, 32'h48, 32'h0, 3'b010, wb, gb);
            xact(1, 1'b0, 32'h4D, 32'h0, 3'b100, wb, gb);
         end
      join
      chk("t2_ngrants", glog.size(), 4);
      for (int i = 0; i < 4 && i < glog.size(); i++) chk($sformatf("t2_order%0d", i), glog[i], exp_ord[i]);

      // 4: access faults and misalignment from m1
      xact(1, 1'b0, 32'h200, 32'h0, 3'b010, w1, g1);
      xact(1, 1'b1, 32'h6, 32'h12345678, 3'b010, w1, g1);
      xact(1, 1'b1, 32'h7C, 32'hCAFEF00D, 3'b010, w1, g1);
      xact(1, 1'b0, 32'h7C, 32'h0, 3'b010, w1, g1);
      xact(0, 1'b0, 32'h4, 32'h0, 3'b010, w0, g0);

      // 5: reset during ACCESS of a word store drops it
      xact(0, 1'b1, 32'h20, 32'h11223344, 3'b010, w0, g0);
      m0_we = 1'b1; m0_addr = 32'h20; m0_wdata = 32'hDEADBEEF; m0_ubhw = 3'b010; m0_req = 1'b1;
      got = 1'b0; k = 0;
      while (!got && k < 50) begin
         @(posedge clk); #1;
         k++;
         got = m0_gnt;
      end
      chk("t5_gnt_seen", got, 1);
      rst = 1'b1; m0_req = 1'b0;
      @(negedge clk);
      chk("t5_no_we_in_rst", {ram_we, ram_re}, 0);
      @(posedge clk); #1;
      chk("t5_idle_after_rst", busy, 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      xact(0, 1'b0, 32'h20, 32'h0, 3'b010, w0, g0);

      // 6: back-to-back on m1 with a halfword store, unsigned half load
      xact(1, 1'b1, 32'h32, 32'h00008001, 3'b001, w1, g0);
      xact(1, 1'b0, 32'h32, 32'h0, 3'b101, w1, g1);
      chk("t6_back_to_back", g1 - g0, 2);
      xact(1, 1'b0, 32'h32, 32'h0, 3'b001, w1, g1);

      repeat (4) @(posedge clk);
      chk("queues_drained", exp_q0.size() + exp_q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
